// File: rtl/cfg_chain_loader.sv
// Configuration-chain loader: serialises bitstream words onto the config flop chain, LSB first.
// Optional CRC-16-CCITT check of the shifted stream is enabled with the CFG_CRC_EN macro.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting words and shifting bits into the chain
// DONE  | one-cycle completion pulse, then back to IDLE
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              cfg_shift_en,
    input  logic [15:0]       expected_crc,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [CNT_W-1:0] LEN  = CNT_W'(CHAIN_LEN);
    // A word never carries more bits than the whole chain.
    localparam logic [CNT_W-1:0] STEP = CNT_W'((WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  word_bits;
    logic [CNT_W-1:0]  remaining;
    logic [WORD_W-1:0] shreg;

    assign remaining = LEN - bit_cnt;
    assign s_ready   = (state == LOAD) && (word_bits == '0) && (bit_cnt < LEN);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            word_bits    <= '0;
            shreg        <= '0;
            ccff_head    <= 1'b0;
            cfg_shift_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            cfg_shift_en <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        word_bits <= '0;
                    end
                end
                LOAD: begin
                    if (word_bits != '0) begin
                        ccff_head    <= shreg[0];
                        cfg_shift_en <= 1'b1;
                        shreg        <= shreg >> 1;
                        word_bits    <= word_bits - 1'b1;
                        bit_cnt      <= bit_cnt + 1'b1;
                    end else if (bit_cnt == LEN) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (s_valid) begin
                        shreg     <= s_data;
                        word_bits <= (remaining > STEP) ? STEP : remaining;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CFG_CRC_EN
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        crc_fb;
    logic        err_q;

    assign crc_fb   = crc[15] ^ shreg[0];
    assign crc_next = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);

    // The bit being shifted this edge is the one that appears on ccff_head next cycle.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            crc   <= 16'hFFFF;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            crc   <= 16'hFFFF;
            err_q <= 1'b0;
        end else if (state == LOAD && word_bits != '0) begin
            crc <= crc_next;
        end else if (state == LOAD && bit_cnt == LEN) begin
            err_q <= (crc != expected_crc);
        end
    end

    assign error = err_q;
`else
    logic unused_crc;
    assign unused_crc = ^expected_crc;
    assign error      = 1'b0;
`endif

endmodule
